rx_source_select: RTL and testbench

- Per-sample source selector on the AD9866 receive path, ahead of the receiver DDCs in hermes_lite_core.
- Generalises the fixed ADC-vs-test-clock choice into a parametrised N-source sample mux: live ADC, ramp, constant and optional PRBS.
- Source changes are glitch-free: outputs are muted for a fixed number of cycles before the new source is taken.
- Also tracks ADC full-scale runs and raises a sticky overrange flag.

---
 rtl/rx_source_select.sv | 143 ++++++++++++++
 tb/tb_rx_source_select.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rx_source_select.sv
// Per-sample receive source mux (ADC / ramp / constant / PRBS) with a muted, glitch-free source change and sticky ADC overrange flag.
// One cycle from input to rx_data, rx_valid every cycle after reset, no backpressure; PRBS source built only with RX_SRC_PRBS_EN.
module rx_source_select #(
   parameter int              DW           = 12,
   parameter int              MUTE_CYCLES  = 16,
   parameter int              FALLBACK_SRC = 1,
   parameter int              RAMP_STEP    = 1,
   parameter logic [DW-1:0]   CONST_VAL    = 'h400,
   parameter int              OVR_RUN      = 4
) (
   input  logic          AD9866clkX1,
   input  logic          rst_n,
   input  logic          exp_present,
   input  logic [1:0]    src_sel,
   input  logic [DW-1:0] adc_data,
   input  logic          ovr_clr,
   output logic [DW-1:0] rx_data,
   output logic          rx_valid,
   output logic [1:0]    active_src,
   output logic          switching,
   output logic          overrange
);

   localparam int            CW        = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
   localparam logic [CW-1:0] MUTE_LAST = CW'(MUTE_CYCLES - 1);
   localparam int            RW        = $clog2(OVR_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX   = RW'(OVR_RUN);
   localparam logic [DW-1:0] FS_POS    = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] FS_NEG    = {1'b1, {(DW-1){1'b0}}};
   localparam logic [1:0]    FB_SRC    = 2'(FALLBACK_SRC);

   typedef enum logic {ST_RUN, ST_MUTE} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          w_load;
   logic [1:0]    r_active, r_eff_q, w_eff;
   logic [DW-1:0] r_ramp, w_src, w_prbs;
   logic [RW-1:0] r_run, w_run_nxt;
   logic          w_fs, w_ovr_set;
   logic          r_ovr, r_rx_valid, r_switch;
   logic [DW-1:0] r_rx_data;

   assign w_eff = exp_present ? src_sel : FB_SRC;

`ifdef RX_SRC_PRBS_EN
   logic [14:0] r_lfsr;

   // Reseeded on every source load so a fresh PRBS selection always starts at all-ones.
   always_ff @(posedge AD9866clkX1) begin
      if (!rst_n || w_load) r_lfsr <= '1;
      else                  r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
   end

   assign w_prbs = DW'(r_lfsr);
`else
   assign w_prbs = '0;
`endif

   always_comb begin
      w_src = '0;
      case (r_active)
         2'd0:    w_src = adc_data;
         2'd1:    w_src = r_ramp;
         2'd2:    w_src = CONST_VAL;
         default: w_src = w_prbs;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_eff != r_active) begin
               w_state_nxt = ST_MUTE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            // A new request mid-mute restarts the quiet period from scratch.
            if (w_eff != r_eff_q) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == MUTE_LAST) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
      endcase
   end

   assign w_fs = (adc_data == FS_POS) || (adc_data == FS_NEG);

   always_comb begin
      w_run_nxt = '0;
      if ((r_active == 2'd0) && w_fs)
         w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
   end

   assign w_ovr_set = (w_run_nxt == RUN_MAX);

   // Previous request is sampled even in reset so a steady select does not restart the first mute.
   always_ff @(posedge AD9866clkX1) r_eff_q <= w_eff;

   always_ff @(posedge AD9866clkX1) begin
      if (!rst_n) begin
         r_state    <= ST_MUTE;
         r_cnt      <= '0;
         r_active   <= FB_SRC;
         r_ramp     <= '0;
         r_run      <= '0;
         r_ovr      <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_switch   <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_run      <= w_run_nxt;
         r_rx_valid <= 1'b1;
         r_switch   <= (r_state == ST_MUTE);
         r_rx_data  <= (r_state == ST_RUN) ? w_src : '0;
         if (w_load) r_active <= w_eff;
         if (w_load)
            r_ramp <= '0;
         else if ((r_state == ST_RUN) && (r_active == 2'd1))
            r_ramp <= r_ramp + DW'(RAMP_STEP);
         if (w_ovr_set)    r_ovr <= 1'b1;
         else if (ovr_clr) r_ovr <= 1'b0;
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign active_src = r_active;
   assign switching  = r_switch;
   assign overrange  = r_ovr;

endmodule

// File: tb/tb_rx_source_select.sv
// Directed bench for rx_source_select: expected samples are queued as stimulus is driven and checked as outputs appear.
module tb_rx_source_select;

   logic        clk;
   logic        rst_n;
   logic        exp_present;
   logic [1:0]  src_sel;
   logic [11:0] adc_data;
   logic        ovr_clr;
   logic [11:0] rx_data;
   logic        rx_valid;
   logic [1:0]  active_src;
   logic        switching;
   logic        overrange;

   typedef struct packed {
      logic [11:0] d;
      logic        v;
      logic        sw;
      logic [1:0]  a;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic chk_en = 1'b0;
   logic [14:0] m;

   rx_source_select dut (
      .AD9866clkX1 (clk),
      .rst_n       (rst_n),
      .exp_present (exp_present),
      .src_sel     (src_sel),
      .adc_data    (adc_data),
      .ovr_clr     (ovr_clr),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .active_src  (active_src),
      .switching   (switching),
      .overrange   (overrange)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Output checker: one queued expectation per clock edge while checking is enabled.
   always @(posedge clk) begin
      if (chk_en) begin
         exp_t e;
         @(negedge clk);
         if (q.size() == 0) begin
            chk("queue_underflow", 16'd1, 16'd0);
         end else begin
            e = q.pop_front();
            chk("rx_data",    {4'd0, rx_data},    {4'd0, e.d});
            chk("rx_valid",   {15'd0, rx_valid},  {15'd0, e.v});
            chk("switching",  {15'd0, switching}, {15'd0, e.sw});
            chk("active_src", {14'd0, active_src}, {14'd0, e.a});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input logic [11:0] d, input logic v, input logic sw, input logic [1:0] a);
      q.push_back('{d: d, v: v, sw: sw, a: a});
      tick();
   endtask

   task automatic mute_seq(input logic [1:0] old_a, input logic [1:0] new_a);
      repeat (15) step(12'd0, 1'b1, 1'b1, old_a);
      step(12'd0, 1'b1, 1'b1, new_a);
   endtask

   task automatic run_adc(input logic [11:0] d, input logic clr, input logic ovr_exp, input string tag);
      adc_data = d;
      ovr_clr  = clr;
      step(d, 1'b1, 1'b0, 2'd0);
      ovr_clr  = 1'b0;
      chk(tag, {15'd0, overrange}, {15'd0, ovr_exp});
   endtask

   initial begin
      rst_n = 1'b0; exp_present = 1'b1; src_sel = 2'd0; adc_data = 12'h123; ovr_clr = 1'b0;
      repeat (3) tick();
      chk("rst_rx_data",    {4'd0, rx_data},     16'h0000);
      chk("rst_rx_valid",   {15'd0, rx_valid},   16'd0);
      chk("rst_switching",  {15'd0, switching},  16'd1);
      chk("rst_active_src", {14'd0, active_src}, 16'd1);
      chk("rst_overrange",  {15'd0, overrange},  16'd0);

      // Release reset onto the ADC: 16 muted samples, then live data one cycle after input.
      rst_n = 1'b1;
      chk_en = 1'b1;
      mute_seq(2'd1, 2'd0);
      step(12'h123, 1'b1, 1'b0, 2'd0);
      adc_data = 12'h0AB; step(12'h0AB, 1'b1, 1'b0, 2'd0);
      adc_data = 12'h5A5; step(12'h5A5, 1'b1, 1'b0, 2'd0);

      // Board absent forces the ramp; run it through a full wrap.
      exp_present = 1'b0;
      step(12'h5A5, 1'b1, 1'b0, 2'd0);
      mute_seq(2'd0, 2'd1);
      for (int i = 0; i < 4098; i++) step(12'(i), 1'b1, 1'b0, 2'd1);

      // Change to constant, then to ramp mid-mute: the mute restarts.
      exp_present = 1'b1; src_sel = 2'd2;
      step(12'd2, 1'b1, 1'b0, 2'd1);
      repeat (8) step(12'd0, 1'b1, 1'b1, 2'd1);
      src_sel = 2'd1;
      step(12'd0, 1'b1, 1'b1, 2'd1);
      mute_seq(2'd1, 2'd1);
      for (int i = 0; i < 4; i++) step(12'(i), 1'b1, 1'b0, 2'd1);

      src_sel = 2'd2;
      step(12'd4, 1'b1, 1'b0, 2'd1);
      mute_seq(2'd1, 2'd2);
      repeat (3) step(12'h400, 1'b1, 1'b0, 2'd2);

      // Back to ADC for overrange runs.
      src_sel = 2'd0; adc_data = 12'h000;
      step(12'h400, 1'b1, 1'b0, 2'd2);
      mute_seq(2'd2, 2'd0);
      repeat (3) run_adc(12'h7FF, 1'b0, 1'b0, "ovr_pos_run3");
      run_adc(12'h000, 1'b0, 1'b0, "ovr_break");
      repeat (3) run_adc(12'h800, 1'b0, 1'b0, "ovr_neg_run3");
      run_adc(12'h800, 1'b0, 1'b1, "ovr_neg_run4");
      repeat (2) run_adc(12'h000, 1'b0, 1'b1, "ovr_sticky");
      run_adc(12'h000, 1'b1, 1'b0, "ovr_clear");
      repeat (3) run_adc(12'h800, 1'b0, 1'b0, "ovr_rerun3");
      run_adc(12'h800, 1'b1, 1'b1, "ovr_set_wins");
      run_adc(12'h000, 1'b0, 1'b1, "ovr_after_set_wins");

      // PRBS source.
      src_sel = 2'd3;
      step(12'h000, 1'b1, 1'b0, 2'd0);
      mute_seq(2'd0, 2'd3);
      m = 15'h7FFF;
      repeat (6) begin
`ifdef RX_SRC_PRBS_EN
         step(12'(m), 1'b1, 1'b0, 2'd3);
`else
         step(12'h000, 1'b1, 1'b0, 2'd3);
`endif
         m = {m[13:0], m[14] ^ m[13]};
      end

      // Ramp, then reset in the middle of it.
      src_sel = 2'd1;
`ifdef RX_SRC_PRBS_EN
      step(12'(m), 1'b1, 1'b0, 2'd3);
`else
      step(12'h000, 1'b1, 1'b0, 2'd3);
`endif
      mute_seq(2'd3, 2'd1);
      for (int i = 0; i < 6; i++) step(12'(i), 1'b1, 1'b0, 2'd1);
      chk("ovr_before_reset", {15'd0, overrange}, 16'd1);
      rst_n = 1'b0;
      step(12'h000, 1'b0, 1'b1, 2'd1);
      chk("ovr_in_reset", {15'd0, overrange}, 16'd0);
      step(12'h000, 1'b0, 1'b1, 2'd1);
      rst_n = 1'b1;
      mute_seq(2'd1, 2'd1);
      step(12'd0, 1'b1, 1'b0, 2'd1);
      step(12'd1, 1'b1, 1'b0, 2'd1);

      #1;
      chk("queue_drained", 16'(q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
